usb_txn_ctrl: RTL and testbench

Host-side transaction sequencer for the USB link. Accepts one IN or OUT transaction request, drives the encoder's packet-type select to emit token, data and handshake packets in order, switches the DP/DM block between write and read, and waits for the device response with a bounded timeout. Retries on NAK, timeout or corrupt response, up to a fixed limit. Sits between the protocol layer above and the encode/DP-DM/decode pipeline below.

---
 rtl/usb_pkg.sv | 27 ++
 rtl/usb_txn_ctrl_timer.sv | 24 ++
 rtl/usb_txn_ctrl.sv | 158 +++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types for the USB host transaction sequencer: packet types, PIDs, FSM states.
package usb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    TOK  = 2'b01,
    DATA = 2'b10,
    HS   = 2'b11
  } pkt_type_t;

  localparam logic [3:0] ACK   = 4'b0010;
  localparam logic [3:0] NAK   = 4'b1010;
  localparam logic [3:0] STALL = 4'b1110;
  localparam logic [3:0] DATA0 = 4'b0011;
  localparam logic [3:0] DATA1 = 4'b1011;

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    OUT_DATA,
    WAIT_HS,
    WAIT_DATA,
    SEND_HS,
    DONE
  } state_t;

endpackage

// File: rtl/usb_txn_ctrl_timer.sv
// Response timeout counter: reads 0 after clear, counts while enabled, flags when it reaches TIMEOUT.
module txn_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == TIMEOUT);

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer (token/data/handshake with NAK/timeout retry).
// Optional retry statistics counter enabled by defining USB_TXN_STATS_EN.
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255,
  parameter logic [3:0] MAX_TRY = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_in,
  output logic       tx_go,
  output logic [1:0] tx_type,
  input  logic       tx_done,
  output logic       re,
  input  logic       rx_done,
  input  logic [3:0] rx_pid,
  input  logic       rx_ok,
  output logic       busy,
  output logic       txn_done,
  output logic       txn_err,
  output logic [7:0] retry_total
);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_isIn;
  logic [3:0] r_tryCnt;
  logic       r_err;
  logic       r_txGo;
  logic       w_fail;
  logic       w_doneErr;
  logic       w_waiting;
  logic       w_expired;
  pkt_type_t  w_txType;

  assign w_waiting = (r_state == WAIT_HS) || (r_state == WAIT_DATA);

  txn_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_waiting),
    .i_enable (w_waiting),
    .o_expired(w_expired)
  );

  // A received packet always takes priority over a timeout expiring in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_fail      = 1'b0;
    w_doneErr   = 1'b0;
    case (r_state)
      IDLE:      if (start) w_nextState = TOKEN;
      TOKEN:     if (tx_done) w_nextState = r_isIn ? WAIT_DATA : OUT_DATA;
      OUT_DATA:  if (tx_done) w_nextState = WAIT_HS;
      WAIT_HS: begin
        if (rx_done) begin
          if (rx_ok && rx_pid == ACK) begin
            w_nextState = DONE;
          end else if (rx_ok && rx_pid == STALL) begin
            w_nextState = DONE;
            w_doneErr   = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (rx_done) begin
          if (rx_ok && (rx_pid == DATA0 || rx_pid == DATA1)) begin
            w_nextState = SEND_HS;
          end else if (rx_ok && rx_pid == STALL) begin
            w_nextState = DONE;
            w_doneErr   = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      SEND_HS:   if (tx_done) w_nextState = DONE;
      DONE:      w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
    if (w_fail) begin
      if (r_tryCnt == MAX_TRY - 4'd1) begin
        w_nextState = DONE;
        w_doneErr   = 1'b1;
      end else begin
        w_nextState = TOKEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_isIn   <= 1'b0;
      r_tryCnt <= 4'd0;
      r_err    <= 1'b0;
      r_txGo   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_txGo  <= (w_nextState != r_state) &&
                 (w_nextState inside {TOKEN, OUT_DATA, SEND_HS});
      if (r_state == IDLE && start) begin
        r_isIn   <= is_in;
        r_tryCnt <= 4'd0;
      end else if (w_fail && w_nextState == TOKEN) begin
        r_tryCnt <= r_tryCnt + 4'd1;
      end
      if (w_nextState == DONE) begin
        r_err <= w_doneErr;
      end
    end
  end

  always_comb begin
    w_txType = NONE;
    case (r_state)
      TOKEN:    w_txType = TOK;
      OUT_DATA: w_txType = DATA;
      SEND_HS:  w_txType = HS;
      default:  w_txType = NONE;
    endcase
  end

  assign tx_go    = r_txGo;
  assign tx_type  = w_txType;
  assign re       = w_waiting;
  assign busy     = (r_state != IDLE);
  assign txn_done = (r_state == DONE);
  assign txn_err  = (r_state == DONE) && r_err;

`ifdef USB_TXN_STATS_EN
  logic [7:0] r_retryTotal;
  logic       w_retry;

  assign w_retry = w_fail && (w_nextState == TOKEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retryTotal <= 8'd0;
    end else if (w_retry && r_retryTotal != 8'hFF) begin
      r_retryTotal <= r_retryTotal + 8'd1;
    end
  end

  assign retry_total = r_retryTotal;
`else
  assign retry_total = 8'd0;
`endif

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed self-checking bench for usb_txn_ctrl with hand-computed expectations.
module tb_usb_txn_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       is_in;
  logic       tx_go;
  logic [1:0] tx_type;
  logic       tx_done;
  logic       re;
  logic       rx_done;
  logic [3:0] rx_pid;
  logic       rx_ok;
  logic       busy;
  logic       txn_done;
  logic       txn_err;
  logic [7:0] retry_total;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_TOK  = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_HS   = 2'b11;

`ifdef USB_TXN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  usb_txn_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_in      (is_in),
    .tx_go      (tx_go),
    .tx_type    (tx_type),
    .tx_done    (tx_done),
    .re         (re),
    .rx_done    (rx_done),
    .rx_pid     (rx_pid),
    .rx_ok      (rx_ok),
    .busy       (busy),
    .txn_done   (txn_done),
    .txn_err    (txn_err),
    .retry_total(retry_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isIn);
    start = 1'b1;
    is_in = isIn;
    tick();
    start = 1'b0;
  endtask

  // Called in the first cycle of a transmit state; completes the packet after one idle cycle.
  task automatic txPacket(input string tag, input logic [1:0] expType);
    checkOutput({tag, " tx_go"}, tx_go, 1);
    checkOutput({tag, " tx_type"}, tx_type, expType);
    checkOutput({tag, " re low while sending"}, re, 0);
    tick();
    checkOutput({tag, " tx_go single pulse"}, tx_go, 0);
    checkOutput({tag, " tx_type held"}, tx_type, expType);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic rxPacket(input logic [3:0] pid, input logic ok);
    rx_done = 1'b1;
    rx_pid  = pid;
    rx_ok   = ok;
    tick();
    rx_done = 1'b0;
    rx_ok   = 1'b0;
    rx_pid  = 4'd0;
  endtask

  int expRetry;
  int waitLen;

  initial begin
    rst = 1'b1; start = 1'b0; is_in = 1'b0; tx_done = 1'b0;
    rx_done = 1'b0; rx_pid = 4'd0; rx_ok = 1'b0;
    expRetry = 0;
    tick();
    tick();
    checkOutput("reset tx_go", tx_go, 0);
    checkOutput("reset tx_type", tx_type, T_NONE);
    checkOutput("reset re", re, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset txn_done", txn_done, 0);
    checkOutput("reset txn_err", txn_err, 0);
    checkOutput("reset retry_total", retry_total, 0);
    rst = 1'b0;
    tick();

    // OUT transaction, device ACKs 5 cycles after the data packet finishes
    applyStimulus(1'b0);
    checkOutput("out busy", busy, 1);
    txPacket("out token", T_TOK);
    txPacket("out data", T_DATA);
    checkOutput("out re in WAIT_HS", re, 1);
    checkOutput("out tx_type idle in wait", tx_type, T_NONE);
    repeat (4) begin
      tick();
      checkOutput("out re holds", re, 1);
    end
    rxPacket(4'b0010, 1'b1);
    checkOutput("out txn_done", txn_done, 1);
    checkOutput("out txn_err", txn_err, 0);
    checkOutput("out re drops", re, 0);
    checkOutput("out busy in DONE", busy, 1);
    tick();
    checkOutput("out txn_done one cycle", txn_done, 0);
    checkOutput("out busy idle", busy, 0);
    checkOutput("out retry_total", retry_total, 0);

    // IN transaction, DATA0 received cleanly, host answers with ACK
    applyStimulus(1'b1);
    txPacket("in token", T_TOK);
    checkOutput("in re in WAIT_DATA", re, 1);
    tick();
    tick();
    rxPacket(4'b0011, 1'b1);
    checkOutput("in re drops", re, 0);
    txPacket("in handshake", T_HS);
    checkOutput("in txn_done", txn_done, 1);
    checkOutput("in txn_err", txn_err, 0);
    tick();

    // OUT transaction: NAK, NAK, ACK
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) begin
      txPacket("nak token", T_TOK);
      txPacket("nak data", T_DATA);
      tick();
      rxPacket((i < 2) ? 4'b1010 : 4'b0010, 1'b1);
      if (i < 2) checkOutput("nak retry restarts token", tx_type, T_TOK);
    end
    expRetry = expRetry + 2 * STATS;
    checkOutput("nak txn_done", txn_done, 1);
    checkOutput("nak txn_err", txn_err, 0);
    checkOutput("nak retry_total", retry_total, expRetry);
    tick();

    // IN transaction with a silent device: 8 attempts, each timing out.
    // The timer reads 0 in the first wait cycle and fires in the cycle it reads 255,
    // so re is seen high for 256 sampled cycles per attempt.
    applyStimulus(1'b1);
    for (int a = 0; a < 8; a++) begin
      txPacket("silent token", T_TOK);
      waitLen = 0;
      while (re && waitLen < 400) begin
        waitLen++;
        tick();
      end
      checkOutput("silent timeout window", waitLen, 256);
      if (a < 7) checkOutput("silent retry token", tx_type, T_TOK);
    end
    expRetry = expRetry + 7 * STATS;
    checkOutput("silent txn_done", txn_done, 1);
    checkOutput("silent txn_err", txn_err, 1);
    checkOutput("silent retry_total", retry_total, expRetry);
    tick();

    // IN transaction answered with STALL: no retry
    applyStimulus(1'b1);
    txPacket("stall token", T_TOK);
    tick();
    rxPacket(4'b1110, 1'b1);
    checkOutput("stall txn_done", txn_done, 1);
    checkOutput("stall txn_err", txn_err, 1);
    checkOutput("stall no retry", retry_total, expRetry);
    tick();

    // DATA1 arriving in the very cycle the timer fires is accepted
    applyStimulus(1'b1);
    txPacket("edge token", T_TOK);
    repeat (255) tick();
    checkOutput("edge still waiting", re, 1);
    rxPacket(4'b1011, 1'b1);
    txPacket("edge handshake", T_HS);
    checkOutput("edge txn_done", txn_done, 1);
    checkOutput("edge txn_err", txn_err, 0);
    checkOutput("edge no retry", retry_total, expRetry);
    tick();

    // start during TOKEN is ignored; reset while in WAIT_DATA
    applyStimulus(1'b1);
    start = 1'b1;
    is_in = 1'b0;
    tick();
    start = 1'b0;
    checkOutput("ignored start tx_go", tx_go, 0);
    checkOutput("ignored start tx_type", tx_type, T_TOK);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checkOutput("ignored start keeps IN", re, 1);
    rst = 1'b1;
    tick();
    checkOutput("midreset re", re, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset txn_done", txn_done, 0);
    checkOutput("midreset tx_type", tx_type, T_NONE);
    checkOutput("midreset retry_total", retry_total, 0);
    rst = 1'b0;
    tick();
    checkOutput("post reset txn_done", txn_done, 0);
    checkOutput("post reset busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
